// File: rtl/led_pwm_fader_if.sv
`default_nettype none
// ============================================================================
//  Module   : led_pwm_fader_if
//  Purpose  : Bundles the pattern/enable inputs and the LED drive/busy outputs
//             of the LED PWM fader.
//  Signals  : led_in  [MAX_LENGTH] - pattern from the sequencer
//             en                   - run enable (0 = freeze and blank)
//             led_out [MAX_LENGTH] - PWM drive to the LEDs
//             busy                 - any channel still lit or fading
//  Modports : master (pattern source), slave (fader)
//  Revision : 1.0 - initial release
// ============================================================================
interface led_pwm_fader_if #(
    parameter int MAX_LENGTH = 8
);
    logic [MAX_LENGTH-1:0] led_in;
    logic                  en;
    logic [MAX_LENGTH-1:0] led_out;
    logic                  busy;

    modport master (
        output led_in,
        output en,
        input  led_out,
        input  busy
    );

    modport slave (
        input  led_in,
        input  en,
        output led_out,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/led_pwm_fader.sv
`default_nettype none
// ============================================================================
//  Module   : led_pwm_fader
//  Purpose  : Per-channel PWM LED driver with a linear "comet tail" fade.
//             A channel whose input bit is high is held at full brightness;
//             once the bit drops, its level decays by one step every
//             FADE_DIV enabled cycles until it reaches zero.
//  Ports    : clk  - system clock, rising edge
//             rst  - synchronous active-high reset
//             bus  - led_pwm_fader_if.slave (led_in, en, led_out, busy)
//  Params   : MAX_LENGTH - number of LED channels
//             PWM_BITS   - width of brightness level and PWM counter
//             FADE_DIV   - enabled cycles per one-step decrement (1..2^16)
//  Options  : LED_PWM_FADER_GAMMA_EN - when defined, partial levels use a
//             squared compare value (level*level >> PWM_BITS) for a more
//             perceptually even fade. Full level is always 100% duty.
//  Revision : 1.0 - initial release
// ============================================================================
module led_pwm_fader #(
    parameter int MAX_LENGTH = 8,
    parameter int PWM_BITS   = 4,
    parameter int FADE_DIV   = 16
) (
    input  logic              clk,
    input  logic              rst,
    led_pwm_fader_if.slave    bus
);

    // FADE_DIV = 1 needs a counter that never leaves 0; keep it 1 bit wide.
    localparam int                  FADE_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [FADE_W-1:0]   FADE_LAST = FADE_W'(FADE_DIV - 1);
    localparam logic [PWM_BITS-1:0] LMAX      = '1;

    logic [PWM_BITS-1:0]   pwm_cnt_q,  pwm_cnt_d;
    logic [FADE_W-1:0]     fade_cnt_q, fade_cnt_d;
    logic [PWM_BITS-1:0]   level_q [MAX_LENGTH];
    logic [PWM_BITS-1:0]   level_d [MAX_LENGTH];
    logic [MAX_LENGTH-1:0] led_out_q,  led_out_d;
    logic [PWM_BITS-1:0]   cmp_val [MAX_LENGTH];
    logic                  fade_tick;
    logic                  busy;

    // ------------------------------------------------------------------
    // Shared PWM and fade-rate counters; both freeze while disabled.
    // ------------------------------------------------------------------
    always_comb begin
        fade_tick  = bus.en && (fade_cnt_q == FADE_LAST);
        pwm_cnt_d  = pwm_cnt_q;
        fade_cnt_d = fade_cnt_q;
        if (bus.en) begin
            pwm_cnt_d  = pwm_cnt_q + 1'b1;
            fade_cnt_d = (fade_cnt_q == FADE_LAST) ? '0 : fade_cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel duty compare value.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < MAX_LENGTH; i++) begin : g_chan
`ifdef LED_PWM_FADER_GAMMA_EN
        logic [2*PWM_BITS-1:0] sq;
        assign sq         = {{PWM_BITS{1'b0}}, level_q[i]} * {{PWM_BITS{1'b0}}, level_q[i]};
        assign cmp_val[i] = PWM_BITS'(sq >> PWM_BITS);
`else
        assign cmp_val[i] = level_q[i];
`endif
    end

    // ------------------------------------------------------------------
    // Level update and PWM output. A load from led_in takes priority over
    // a coincident fade step so a retrigger never loses a step of tail.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < MAX_LENGTH; i++) begin
            level_d[i]   = level_q[i];
            led_out_d[i] = 1'b0;
            if (bus.en) begin
                if (bus.led_in[i]) begin
                    level_d[i] = LMAX;
                end else if (fade_tick && (level_q[i] != '0)) begin
                    level_d[i] = level_q[i] - 1'b1;
                end
                // Full level is forced on: cmp > pwm_cnt can never reach
                // 2^PWM_BITS high cycles per period on its own.
                if (level_q[i] == LMAX) begin
                    led_out_d[i] = 1'b1;
                end else begin
                    led_out_d[i] = (cmp_val[i] > pwm_cnt_q);
                end
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < MAX_LENGTH; i++) begin
            busy = busy | (level_q[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_q  <= '0;
            fade_cnt_q <= '0;
            led_out_q  <= '0;
            for (int i = 0; i < MAX_LENGTH; i++) begin
                level_q[i] <= '0;
            end
        end else begin
            pwm_cnt_q  <= pwm_cnt_d;
            fade_cnt_q <= fade_cnt_d;
            led_out_q  <= led_out_d;
            for (int i = 0; i < MAX_LENGTH; i++) begin
                level_q[i] <= level_d[i];
            end
        end
    end

    assign bus.led_out = led_out_q;
    assign bus.busy    = busy;

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_fader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_pwm_fader
//  Purpose  : Self-checking bench for led_pwm_fader (MAX_LENGTH=8,
//             PWM_BITS=4, FADE_DIV=16). Directed per-cycle vector table plus
//             multi-cycle sequences for fade, retrigger, collision, freeze
//             and mid-fade reset. Honours LED_PWM_FADER_GAMMA_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_led_pwm_fader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    led_pwm_fader_if #(.MAX_LENGTH(8)) bus ();

    led_pwm_fader #(
        .MAX_LENGTH (8),
        .PWM_BITS   (4),
        .FADE_DIV   (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] led_in;
        logic [7:0] exp_out;
        logic       exp_busy;
    } vec_t;

    vec_t vecs [13];

    // High cycles in one 16-cycle PWM period at a steady level.
    function automatic int gval(input int lvl);
        if (lvl >= 15) return 16;
`ifdef LED_PWM_FADER_GAMMA_EN
        return (lvl * lvl) >> 4;
`else
        return lvl;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic count_win(input int n, input int ch, output int highs, output int stray);
        highs = 0;
        stray = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (bus.led_out[ch]) highs++;
            for (int b = 0; b < 8; b++) begin
                if (b != ch && bus.led_out[b]) stray++;
            end
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        bus.en     = 1'b1;
        bus.led_in = 8'h00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One-cycle pulse on led_in; returns right after that edge (edge N).
    task automatic pulse(input logic [7:0] pat);
        bus.led_in = pat;
        tick();
        bus.led_in = 8'h00;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int h, s, w, zeros;
        string nm;

        //             rst   en    led_in  exp_out exp_busy
        vecs[0]  = '{1'b1, 1'b1, 8'hFF, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 8'hFF, 8'h00, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 8'hFF, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 8'hFF, 8'h00, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 8'h00, 8'hFF, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 8'hFF, 8'h00, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 8'h00, 8'h00, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 8'hFF, 8'h00, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 8'hA5, 8'h00, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 8'h00, 8'hA5, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b0};

        rst        = 1'b1;
        bus.en     = 1'b1;
        bus.led_in = 8'h00;

        for (int i = 0; i < 13; i++) begin
            rst        = vecs[i].rst;
            bus.en     = vecs[i].en;
            bus.led_in = vecs[i].led_in;
            tick();
            nm = $sformatf("vec%0d_led_out", i);
            chk(nm, bus.led_out, vecs[i].exp_out);
            nm = $sformatf("vec%0d_busy", i);
            chk(nm, bus.busy, vecs[i].exp_busy);
        end

        // ---------------- single pulse, full fade ----------------
        do_reset();
        pulse(8'h01);
        chk("pulse_edge_n", bus.led_out, 8'h00);
        tick();
        chk("pulse_edge_n1", bus.led_out, 8'h01);
        count_win(14, 0, h, s);
        chk("pulse_l15_rest", h, 14);
        zeros = s;
        for (int lvl = 14; lvl >= 1; lvl--) begin
            count_win(16, 0, h, s);
            zeros += s;
            nm = $sformatf("pulse_period_l%0d", lvl);
            chk(nm, h, gval(lvl));
        end
        chk("pulse_other_ch", zeros, 0);
        w = 0;
        while (bus.busy && w < 17) begin
            tick();
            w++;
        end
        chk("pulse_busy_fall", bus.busy, 1'b0);
        count_win(16, 0, h, s);
        chk("pulse_dark", h, 0);

        // ---------------- retrigger at level 5 ----------------
        do_reset();
        pulse(8'h01);
        for (int k = 0; k < 159; k++) tick();
        bus.led_in = 8'h01;
        tick();
        bus.led_in = 8'h00;
        w = bus.led_out[0] ? 1 : 0;
        count_win(15, 0, h, s);
        chk("retrig_full16", h + w, 16);
        count_win(16, 0, h, s);
        chk("retrig_next_l14", h, gval(14));

        // ---------------- load vs fade_tick collision ----------------
        do_reset();
        pulse(8'h08);
        for (int k = 0; k < 110; k++) tick();
        bus.led_in = 8'h08;
        tick();
        bus.led_in = 8'h00;
        count_win(16, 3, h, s);
        chk("collide_l15", h, 16);
        chk("collide_other_ch", s, 0);
        count_win(16, 3, h, s);
        chk("collide_next_l14", h, gval(14));

        // ---------------- enable freeze at level 10 ----------------
        do_reset();
        pulse(8'h01);
        for (int k = 0; k < 83; k++) tick();
        bus.en = 1'b0;
        zeros  = 0;
        w      = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.led_out != 8'h00) zeros++;
            if (!bus.busy) w++;
        end
        chk("freeze_blank", zeros, 0);
        chk("freeze_busy_held", w, 0);
        bus.en = 1'b1;
        count_win(12, 0, h, s);
        chk("freeze_resume_l10", h, (gval(10) > 4) ? gval(10) - 4 : 0);
        count_win(16, 0, h, s);
        chk("freeze_next_l9", h, gval(9));

        // ---------------- reset mid-fade at level 7 ----------------
        do_reset();
        pulse(8'h01);
        for (int k = 0; k < 127; k++) tick();
        chk("midrst_busy_before", bus.busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_led_out", bus.led_out, 8'h00);
        count_win(16, 0, h, s);
        chk("midrst_dark", h + s, 0);
        chk("midrst_busy_after", bus.busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
